// File: rtl/mlaccel_bankmem.sv
// Word-interleaved banked memory with two valid/ready request channels and pipelined read return.
// Define MLACCEL_BANKMEM_ZERO_EN to build the INIT sequencer that zeroes every row after reset.
module mlaccel_bankmem #(
  parameter int ADDR_BITS = 17,
  parameter int NUM_BANKS = 4,
  parameter int READ_LAT  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic                 a_wen,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [31:0]          a_wdata,
  input  logic [3:0]           a_wstrb,
  output logic                 a_rvalid,
  output logic [31:0]          a_rdata,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic                 b_wen,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [31:0]          b_wdata,
  input  logic [3:0]           b_wstrb,
  output logic                 b_rvalid,
  output logic [31:0]          b_rdata,
  output logic                 init_done
);

  // Handshake: a request transfers in any cycle where valid && ready. Valid never depends
  // on ready; ready may depend on the other channel's valid (bank conflict arbitration).
  // A requester holds its request stable until accepted.

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int ROW_BITS  = WORD_BITS - BANK_BITS;
  localparam int ROWS      = 1 << ROW_BITS;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

`ifdef MLACCEL_BANKMEM_ZERO_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_BOOT;
`endif

  state_t state_q, state_d;

  logic [31:0] mem [NUM_BANKS][ROWS];

  logic [WORD_BITS-1:0] a_word, b_word;
  logic [BW-1:0]        a_bank, b_bank;
  logic [ROW_BITS-1:0]  a_row, b_row;
  logic                 conflict, prio_q;
  logic                 a_acc, b_acc, a_rd_acc, b_rd_acc;
  logic                 a_v1, b_v1;
  logic [31:0]          a_d1, b_d1;
  logic                 unused_addr_lsbs;

  assign a_word = a_addr[ADDR_BITS-1:2];
  assign b_word = b_addr[ADDR_BITS-1:2];
  assign a_row  = a_word[WORD_BITS-1 -: ROW_BITS];
  assign b_row  = b_word[WORD_BITS-1 -: ROW_BITS];
  assign unused_addr_lsbs = ^{a_addr[1:0], b_addr[1:0]};

  generate
    if (NUM_BANKS > 1) begin : g_banked
      assign a_bank = a_word[BANK_BITS-1:0];
      assign b_bank = b_word[BANK_BITS-1:0];
    end else begin : g_single
      assign a_bank = '0;
      assign b_bank = '0;
    end
  endgenerate

  assign init_done = (state_q == S_RUN);

  // prio_q: 0 grants A on a conflict, 1 grants B; it flips only on conflict cycles.
  always_comb begin
    conflict = a_valid & b_valid & (a_bank == b_bank);
    a_ready  = init_done & ~(conflict & prio_q);
    b_ready  = init_done & ~(conflict & ~prio_q);
    a_acc    = a_valid & a_ready;
    b_acc    = b_valid & b_ready;
    a_rd_acc = a_acc & ~a_wen;
    b_rd_acc = b_acc & ~b_wen;
  end

`ifdef MLACCEL_BANKMEM_ZERO_EN
  logic [ROW_BITS-1:0] init_row_q, init_row_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef MLACCEL_BANKMEM_ZERO_EN
    init_row_d = init_row_q;
`endif
    case (state_q)
      S_BOOT: state_d = S_RUN;
`ifdef MLACCEL_BANKMEM_ZERO_EN
      S_INIT: begin
        init_row_d = init_row_q + 1'b1;
        if (init_row_q == ROW_BITS'(ROWS - 1)) state_d = S_RUN;
      end
`endif
      S_RUN:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      prio_q  <= 1'b0;
`ifdef MLACCEL_BANKMEM_ZERO_EN
      init_row_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (conflict && init_done) prio_q <= ~prio_q;
`ifdef MLACCEL_BANKMEM_ZERO_EN
      init_row_q <= init_row_d;
`endif
    end
  end

  // Array is not reset; accepted A and B accesses always target different banks.
  always_ff @(posedge clock) begin
`ifdef MLACCEL_BANKMEM_ZERO_EN
    if (state_q == S_INIT) begin
      for (int k = 0; k < NUM_BANKS; k++) mem[BW'(k)][init_row_q] <= '0;
    end
`endif
    if (a_acc && a_wen) begin
      for (int i = 0; i < 4; i++)
        if (a_wstrb[i]) mem[a_bank][a_row][8*i +: 8] <= a_wdata[8*i +: 8];
    end
    if (b_acc && b_wen) begin
      for (int i = 0; i < 4; i++)
        if (b_wstrb[i]) mem[b_bank][b_row][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_rd_acc;
      b_v1 <= b_rd_acc;
      if (a_rd_acc) a_d1 <= mem[a_bank][a_row];
      if (b_rd_acc) b_d1 <= mem[b_bank][b_row];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        a_v2, b_v2;
      logic [31:0] a_d2, b_d2;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
          a_d2 <= '0;
          b_d2 <= '0;
        end else begin
          a_v2 <= a_v1;
          b_v2 <= b_v1;
          if (a_v1) a_d2 <= a_d1;
          if (b_v1) b_d2 <= b_d1;
        end
      end
      assign a_rvalid = a_v2;
      assign b_rvalid = b_v2;
      assign a_rdata  = a_d2;
      assign b_rdata  = b_d2;
    end else begin : g_lat1
      assign a_rvalid = a_v1;
      assign b_rvalid = b_v1;
      assign a_rdata  = a_d1;
      assign b_rdata  = b_d1;
    end
  endgenerate

endmodule

// File: tb/tb_mlaccel_bankmem.sv
// Directed bench for mlaccel_bankmem: vector table, byte fill/readback, parallel and conflicting
// traffic, strobes, mid-flight reset and init timing.
module tb_mlaccel_bankmem;
  localparam int AB = 17;
  localparam int NB = 4;
  localparam int RL = 1;
`ifdef MLACCEL_BANKMEM_ZERO_EN
  localparam int EXP_INIT = (1 << (AB - 2)) / NB;
`else
  localparam int EXP_INIT = 1;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, a_ready, a_wen, a_rvalid;
  logic [AB-1:0] a_addr;
  logic [31:0]   a_wdata, a_rdata;
  logic [3:0]    a_wstrb;
  logic          b_valid, b_ready, b_wen, b_rvalid;
  logic [AB-1:0] b_addr;
  logic [31:0]   b_wdata, b_rdata;
  logic [3:0]    b_wstrb;
  logic          init_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mlaccel_bankmem #(.ADDR_BITS(AB), .NUM_BANKS(NB), .READ_LAT(RL)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_wen(a_wen), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_wstrb(a_wstrb), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wen(b_wen), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_wstrb(b_wstrb), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic        port;
    logic        wen;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_valid = 0; a_wen = 0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = 0; b_wen = 0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic wen, input logic [AB-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    a_valid = 1; a_wen = wen; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
  endtask

  task automatic drive_b(input logic wen, input logic [AB-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    b_valid = 1; b_wen = wen; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    idle();
    if (v.port) drive_b(v.wen, v.addr, v.wdata, v.wstrb);
    else        drive_a(v.wen, v.addr, v.wdata, v.wstrb);
    @(negedge clock);
    check($sformatf("vec%0d_ready", idx), v.port ? b_ready : a_ready, 1);
    next_cycle();
    idle();
    for (int c = 1; c <= RL; c++) begin
      @(negedge clock);
      check($sformatf("vec%0d_rvalid_c%0d", idx, c), v.port ? b_rvalid : a_rvalid,
            (c == RL) ? v.exp_rvalid : 1'b0);
      if (c == RL) check($sformatf("vec%0d_rdata", idx), v.port ? b_rdata : a_rdata, v.exp_rdata);
      next_cycle();
    end
  endtask

  function automatic logic [31:0] fill_word(input int k);
    return {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
  endfunction

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 10000) begin
      next_cycle();
      n++;
    end
    check(name, n, EXP_INIT);
  endtask

  initial begin
    int rdy_err;
    vec_t v;
    vecs[0]  = '{0, 1, 17'h00020, 32'h11223344, 4'b1111, 0, 32'h0};
    vecs[1]  = '{0, 1, 17'h00020, 32'hDEADBEEF, 4'b0101, 0, 32'h0};
    vecs[2]  = '{0, 0, 17'h00020, 32'h0,        4'b0000, 1, 32'h11AD33EF};
    vecs[3]  = '{0, 1, 17'h00020, 32'hFFFFFFFF, 4'b0000, 0, 32'h11AD33EF};
    vecs[4]  = '{0, 0, 17'h00022, 32'h0,        4'b0000, 1, 32'h11AD33EF};
    vecs[5]  = '{1, 1, 17'h00024, 32'hCAFEF00D, 4'b1111, 0, 32'h0};
    vecs[6]  = '{1, 1, 17'h00024, 32'h00000000, 4'b1010, 0, 32'h0};
    vecs[7]  = '{1, 0, 17'h00024, 32'h0,        4'b0000, 1, 32'h00FE000D};
    vecs[8]  = '{1, 0, 17'h00020, 32'h0,        4'b0000, 1, 32'h11AD33EF};
    vecs[9]  = '{0, 1, 17'h1FFFC, 32'h12345678, 4'b1111, 0, 32'h11AD33EF};
    vecs[10] = '{0, 0, 17'h1FFFC, 32'h0,        4'b0000, 1, 32'h12345678};
    vecs[11] = '{0, 0, 17'h00027, 32'h0,        4'b0000, 1, 32'h00FE000D};

    // reset values, with requests present during reset
    idle();
    reset = 1;
    a_valid = 1; b_valid = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_init_done", init_done, 0);
    next_cycle();
    idle();
    reset = 0;
    @(negedge clock);
    check("init_done_before_edge", init_done, 0);
    wait_init("init_latency");

`ifdef MLACCEL_BANKMEM_ZERO_EN
    v = '{0, 0, 17'h1FFFC, 32'h0, 4'b0000, 1, 32'h0};
    apply_vec(v, 99);
`endif

    // table-driven strobes, hold behaviour, cross-port visibility
    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // byte fill: one lane per request, back to back
    rdy_err = 0;
    for (int i = 0; i < 1000; i++) begin
      drive_a(1, AB'(i), {4{8'(i)}}, 4'(1 << (i % 4)));
      @(negedge clock);
      if (a_ready !== 1'b1) rdy_err++;
      next_cycle();
    end
    idle();
    check("fill_stalls", rdy_err, 0);

    // word readback, one read per cycle, scoreboarded
    rdy_err = 0;
    for (int c = 0; c < 250 + RL; c++) begin
      if (c < 250) begin
        drive_a(0, AB'(4*c), '0, '0);
        exp_q.push_back(fill_word(c));
      end else idle();
      @(negedge clock);
      if (c < 250 && a_ready !== 1'b1) rdy_err++;
      check($sformatf("sweep_rvalid_c%0d", c), a_rvalid, (c >= RL) ? 1'b1 : 1'b0);
      if (a_rvalid && exp_q.size() > 0) check($sformatf("sweep_rdata_c%0d", c), a_rdata, exp_q.pop_front());
      next_cycle();
    end
    check("sweep_stalls", rdy_err, 0);
    check("sweep_leftover", exp_q.size(), 0);

    // parallel traffic to different banks
    for (int c = 0; c < 8 + RL; c++) begin
      idle();
      if (c < 8) begin
        drive_a(0, 17'h0, '0, '0);
        drive_b(0, 17'h4, '0, '0);
      end
      @(negedge clock);
      if (c < 8) check($sformatf("par_ready_c%0d", c), {a_ready, b_ready}, 2'b11);
      check($sformatf("par_rvalid_c%0d", c), {a_rvalid, b_rvalid}, (c >= RL) ? 2'b11 : 2'b00);
      if (c >= RL) begin
        check("par_a_rdata", a_rdata, fill_word(0));
        check("par_b_rdata", b_rdata, fill_word(1));
      end
      next_cycle();
    end
    idle();

    // same-bank conflict: grants alternate A,B,A,B,A,B
    for (int c = 0; c < 6 + RL; c++) begin
      idle();
      if (c < 6) begin
        drive_a(0, 17'h10, '0, '0);
        drive_b(0, 17'h10, '0, '0);
      end
      @(negedge clock);
      if (c < 6) check($sformatf("conf_grant_c%0d", c), {a_ready, b_ready},
                       (c % 2 == 0) ? 2'b10 : 2'b01);
      if (c >= RL) begin
        check($sformatf("conf_rvalid_c%0d", c), {a_rvalid, b_rvalid},
              ((c - RL) % 2 == 0) ? 2'b10 : 2'b01);
        check("conf_rdata", ((c - RL) % 2 == 0) ? a_rdata : b_rdata, fill_word(4));
      end
      next_cycle();
    end

    // one more conflict leaves prio at B before the reset
    idle();
    drive_a(0, 17'h10, '0, '0);
    drive_b(0, 17'h10, '0, '0);
    @(negedge clock);
    check("odd_conf_grant", {a_ready, b_ready}, 2'b10);
    next_cycle();

    // reads in flight on both ports, then reset
    idle();
    drive_a(0, 17'h8, '0, '0);
    drive_b(0, 17'hC, '0, '0);
    @(negedge clock);
    check("pre_rst_ready", {a_ready, b_ready}, 2'b11);
    next_cycle();
    reset = 1;
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("midrst_rvalid_c%0d", c), {a_rvalid, b_rvalid}, 2'b00);
      check("midrst_rdata", {a_rdata, b_rdata} == 64'h0, 1);
      check("midrst_ready", {a_ready, b_ready, init_done}, 3'b000);
      next_cycle();
    end
    reset = 0;
    @(negedge clock);
    check("post_rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    wait_init("reinit_latency");
    drive_a(0, 17'h10, '0, '0);
    drive_b(0, 17'h10, '0, '0);
    @(negedge clock);
    check("post_rst_prio_a", {a_ready, b_ready}, 2'b10);
    next_cycle();
    idle();
    for (int c = 1; c <= RL; c++) begin
      @(negedge clock);
      check("post_rst_rvalid_a", {a_rvalid, b_rvalid}, (c == RL) ? 2'b10 : 2'b00);
      if (c == RL) check("post_rst_rdata", a_rdata, fill_word(4));
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
